// File: rtl/mmio_sensor_bridge.sv
// mmio_sensor_bridge
// Memory-mapped responder sitting beside dmem. The top 256-word window
// (0xF00-0xFFF) is claimed here; all other addresses pass through to dmem.
// Inside the window it exposes a sensor sample FIFO (status, head, pop,
// overflow clear) and one brightness register per LED, which feeds a
// free-running PWM comparator that drives the light array.

module mmio_sensor_bridge #(
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 12,
  parameter int NUM_LEDS   = 8,
  parameter int PWM_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         address_dmem,
  input  logic [31:0]         data,
  input  logic                wren,
  output logic                mmio_sel,
  output logic                dmem_wren,
  output logic [31:0]         q_mmio,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [NUM_LEDS-1:0] led_out
);

  // Pointer width covers FIFO_DEPTH entries; the count needs one extra bit
  // so that "full" (count == FIFO_DEPTH) is representable.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_SDATA  = 8'h01;
  localparam logic [7:0] ADDR_POP    = 8'h02;
  localparam logic [7:0] ADDR_CLR    = 8'h03;
  localparam logic [7:0] ADDR_BRIGHT = 8'h10;

  // Sample storage and FIFO bookkeeping
  logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow;

  // LED brightness registers and the shared PWM timebase
  logic [PWM_W-1:0]    bright [NUM_LEDS];
  logic [PWM_W-1:0]    pwm_cnt;

  // Decoded bus request
  logic [7:0]          reg_addr;
  logic                reg_wr;
  logic                pop_req;
  logic                clr_req;

  // FIFO control for this cycle
  logic                fifo_empty;
  logic                fifo_full;
  logic                do_pop;
  logic                do_push;
  logic                drop_sample;

  // Read-side helpers
  logic [31:0]         status_word;
  logic [31:0]         head_word;

  // Only the low PWM_W bits of write data reach the brightness registers;
  // the rest of the word is intentionally discarded.
  generate
    if (PWM_W < 32) begin : g_unused_data
      logic unused_data_bits;
      assign unused_data_bits = ^data[31:PWM_W];
    end
  endgenerate

  // Window decode and the dmem write gate are pure address logic so the
  // processor sees the read mux select with no added latency.
  assign mmio_sel  = (address_dmem[11:8] == 4'hF);
  assign dmem_wren = wren & ~mmio_sel;
  assign reg_addr  = address_dmem[7:0];
  assign reg_wr    = wren & mmio_sel;
  assign pop_req   = reg_wr && (reg_addr == ADDR_POP);
  assign clr_req   = reg_wr && (reg_addr == ADDR_CLR) && data[0];

  // A push is blocked only when the FIFO is full and nothing leaves it in the
  // same cycle; a pop on an empty FIFO is simply ignored.
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_CNT);
  assign do_pop      = pop_req & ~fifo_empty;
  assign do_push     = sample_valid & (~fifo_full | do_pop);
  assign drop_sample = sample_valid & fifo_full & ~do_pop;

  // Sample storage is not reset: entries are only visible between push and
  // pop, and an empty FIFO always reads back zero.
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= sample_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag; a dropped sample
  // takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_sample) begin
        overflow <= 1'b1;
      end else if (clr_req) begin
        overflow <= 1'b0;
      end
    end
  end

  // Brightness registers, one per LED, written through the window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        bright[i] <= '0;
      end
    end else if (reg_wr) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (reg_addr == (ADDR_BRIGHT + 8'(i))) begin
          bright[i] <= data[PWM_W-1:0];
        end
      end
    end
  end

  // Free-running PWM timebase shared by every LED, wrapping naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // LED drive compares the timebase against each brightness, so a new value
  // is seen on the cycle after its write and zero keeps the LED dark.
  always_comb begin
    led_out = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_out[i] = (pwm_cnt < bright[i]);
    end
  end

  // Status and head-of-FIFO words assembled for the read mux.
  always_comb begin
    status_word       = '0;
    status_word[7:0]  = 8'(count);
    status_word[8]    = fifo_empty;
    status_word[9]    = fifo_full;
    status_word[10]   = overflow;
    head_word         = '0;
    if (!fifo_empty) begin
      head_word = 32'(fifo_mem[rd_ptr]);
    end
  end

  // Read mux: zero outside the window and at unmapped or write-only offsets.
  always_comb begin
    q_mmio = '0;
    if (mmio_sel) begin
      case (reg_addr)
        ADDR_STATUS: q_mmio = status_word;
        ADDR_SDATA:  q_mmio = head_word;
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (reg_addr == (ADDR_BRIGHT + 8'(i))) begin
              q_mmio = 32'(bright[i]);
            end
          end
        end
      endcase
    end
  end

endmodule
